qpsk_symbol_tx: RTL and testbench

- Transmit-side counterpart of the Gardner timing-recovery receiver.
- Accepts 2-bit QPSK symbols over a valid/ready handshake and emits signed 16-bit I/Q sample streams at SPS samples per symbol.
- Each sample is held for CLKS_PER_SAMPLE clocks, matching the receiver's ADC-style input.
- Symbol transitions use linear interpolation, so alternating symbols produce mid-symbol zero crossings for the timing-error detector. Used as a stimulus source and loopback driver for Top.

---
 rtl/qpsk_tx_pkg.sv | 23 ++
 rtl/tx_interp.sv | 30 +++
 rtl/qpsk_symbol_tx.sv | 144 ++++++++++++++
 tb/tb_qpsk_symbol_tx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qpsk_tx_pkg.sv
// Shared types, constants and the symbol-to-level mapping for the QPSK symbol transmitter.
package qpsk_tx_pkg;

  localparam int unsigned SAMPLE_W = 16;

  typedef struct packed {
    logic i_bit;
    logic q_bit;
  } sym_t;

  // PRBS-9 (x^9 + x^5 + 1), Fibonacci form: feedback from bits 8 and 4
  localparam logic [8:0]  PRBS9_SEED  = 9'h1FF;
  localparam int unsigned PRBS9_TAP_A = 8;
  localparam int unsigned PRBS9_TAP_B = 4;

  function automatic logic signed [SAMPLE_W-1:0] map_level(input logic b,
                                                           input logic [SAMPLE_W-1:0] amp);
    logic signed [SAMPLE_W-1:0] a;
    a = signed'(amp);
    return b ? -a : a;
  endfunction

endpackage

// File: rtl/tx_interp.sv
// One-rail linear interpolator: blends prev and curr levels by phase, floor-divides by SPS.
module tx_interp
  import qpsk_tx_pkg::*;
#(
  parameter int unsigned SPS      = 2,
  parameter int unsigned LOG2_SPS = $clog2(SPS)
) (
  input  logic signed [SAMPLE_W-1:0] prev_i,
  input  logic signed [SAMPLE_W-1:0] curr_i,
  input  logic        [LOG2_SPS-1:0] phase_i,
  output logic signed [SAMPLE_W-1:0] sample_o
);

  localparam int unsigned AccW = SAMPLE_W + LOG2_SPS + 1;
  localparam int unsigned WgtW = LOG2_SPS + 2;

  logic        [WgtW-1:0] wgt_curr;
  logic        [WgtW-1:0] wgt_prev;
  logic signed [AccW-1:0] acc;

  always_comb begin
    wgt_curr = {2'b00, phase_i} + WgtW'(1);
    wgt_prev = WgtW'(SPS) - wgt_curr;
    // Weights sum to SPS, so the accumulator never exceeds |level| * SPS
    acc      = AccW'(prev_i) * AccW'(signed'(wgt_prev)) +
               AccW'(curr_i) * AccW'(signed'(wgt_curr));
    sample_o = SAMPLE_W'(acc >>> LOG2_SPS);
  end

endmodule

// File: rtl/qpsk_symbol_tx.sv
// QPSK symbol transmitter: valid/ready symbol intake, interpolated I/Q samples every
// CLKS_PER_SAMPLE clocks. Define QPSK_TX_PRBS_EN to add the prbs_sel internal PRBS-9 source.
module qpsk_symbol_tx
  import qpsk_tx_pkg::*;
#(
  parameter int unsigned SPS             = 2,
  parameter int unsigned CLKS_PER_SAMPLE = 10,
  parameter int unsigned AMP_I           = 23000,
  parameter int unsigned AMP_Q           = 25000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sym_valid,
  input  logic [1:0]                 sym_data,
`ifdef QPSK_TX_PRBS_EN
  input  logic                       prbs_sel,
`endif
  output logic                       sym_ready,
  output logic signed [SAMPLE_W-1:0] I_out,
  output logic signed [SAMPLE_W-1:0] Q_out,
  output logic                       sample_stb,
  output logic                       underrun
);

  localparam int unsigned LOG2_SPS = $clog2(SPS);
  localparam int unsigned CntW     = $clog2(CLKS_PER_SAMPLE);
  localparam logic [CntW-1:0]     CntMax = CntW'(CLKS_PER_SAMPLE - 1);
  localparam logic [LOG2_SPS-1:0] PhMax  = LOG2_SPS'(SPS - 1);

  logic [CntW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [LOG2_SPS-1:0] phase_q, phase_d;
  logic signed [SAMPLE_W-1:0] prev_i_q, prev_i_d, curr_i_q, curr_i_d;
  logic signed [SAMPLE_W-1:0] prev_q_q, prev_q_d, curr_q_q, curr_q_d;
  logic signed [SAMPLE_W-1:0] i_out_q, i_out_d, q_out_q, q_out_d;
  logic signed [SAMPLE_W-1:0] i_samp, q_samp;
  logic sample_stb_q, sample_stb_d;
  logic underrun_q, underrun_d;
  logic tick, slot;
  logic src_valid;
  sym_t src_sym;

  assign tick = (clk_cnt_q == CntMax);
  assign slot = tick && (phase_q == PhMax);

`ifdef QPSK_TX_PRBS_EN
  logic [8:0] lfsr_q, lfsr_d, lfsr_step1, lfsr_step2;
  logic       prbs_b0, prbs_b1;

  // Two LFSR steps per slot: first shifted bit drives I, second drives Q
  always_comb begin
    prbs_b0    = lfsr_q[PRBS9_TAP_A] ^ lfsr_q[PRBS9_TAP_B];
    lfsr_step1 = {lfsr_q[7:0], prbs_b0};
    prbs_b1    = lfsr_step1[PRBS9_TAP_A] ^ lfsr_step1[PRBS9_TAP_B];
    lfsr_step2 = {lfsr_step1[7:0], prbs_b1};
    lfsr_d     = (slot && prbs_sel) ? lfsr_step2 : lfsr_q;
    src_sym    = prbs_sel ? '{i_bit: prbs_b0, q_bit: prbs_b1} : sym_t'(sym_data);
    src_valid  = prbs_sel | sym_valid;
    sym_ready  = slot & ~reset & ~prbs_sel;
  end
`else
  always_comb begin
    src_sym   = sym_t'(sym_data);
    src_valid = sym_valid;
    sym_ready = slot & ~reset;
  end
`endif

  always_comb begin
    clk_cnt_d  = tick ? '0 : clk_cnt_q + CntW'(1);
    phase_d    = tick ? phase_q + LOG2_SPS'(1) : phase_q;
    prev_i_d   = prev_i_q;
    curr_i_d   = curr_i_q;
    prev_q_d   = prev_q_q;
    curr_q_d   = curr_q_q;
    underrun_d = underrun_q;
    if (slot) begin
      prev_i_d = curr_i_q;
      prev_q_d = curr_q_q;
      if (src_valid) begin
        curr_i_d = map_level(src_sym.i_bit, SAMPLE_W'(AMP_I));
        curr_q_d = map_level(src_sym.q_bit, SAMPLE_W'(AMP_Q));
      end else begin
        curr_i_d   = '0;
        curr_q_d   = '0;
        underrun_d = 1'b1;
      end
    end
    sample_stb_d = tick;
    i_out_d      = tick ? i_samp : i_out_q;
    q_out_d      = tick ? q_samp : q_out_q;
  end

  tx_interp #(.SPS(SPS)) u_interp_i (
    .prev_i   (prev_i_d),
    .curr_i   (curr_i_d),
    .phase_i  (phase_d),
    .sample_o (i_samp)
  );

  tx_interp #(.SPS(SPS)) u_interp_q (
    .prev_i   (prev_q_d),
    .curr_i   (curr_q_d),
    .phase_i  (phase_d),
    .sample_o (q_samp)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_cnt_q    <= '0;
      phase_q      <= PhMax;
      prev_i_q     <= '0;
      curr_i_q     <= '0;
      prev_q_q     <= '0;
      curr_q_q     <= '0;
      i_out_q      <= '0;
      q_out_q      <= '0;
      sample_stb_q <= 1'b0;
      underrun_q   <= 1'b0;
`ifdef QPSK_TX_PRBS_EN
      lfsr_q       <= PRBS9_SEED;
`endif
    end else begin
      clk_cnt_q    <= clk_cnt_d;
      phase_q      <= phase_d;
      prev_i_q     <= prev_i_d;
      curr_i_q     <= curr_i_d;
      prev_q_q     <= prev_q_d;
      curr_q_q     <= curr_q_d;
      i_out_q      <= i_out_d;
      q_out_q      <= q_out_d;
      sample_stb_q <= sample_stb_d;
      underrun_q   <= underrun_d;
`ifdef QPSK_TX_PRBS_EN
      lfsr_q       <= lfsr_d;
`endif
    end
  end

  assign I_out      = i_out_q;
  assign Q_out      = q_out_q;
  assign sample_stb = sample_stb_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_qpsk_symbol_tx.sv
// Scoreboard bench for qpsk_symbol_tx (SPS=2 main instance plus an SPS=4 instance).
module tb_qpsk_symbol_tx;

  localparam int SPS  = 2;
  localparam int CLKS = 10;
  localparam int AI   = 23000;
  localparam int AQ   = 25000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sym_valid = 1'b0;
  logic [1:0] sym_data = 2'b00;
  logic prbs_sel = 1'b0;
  logic sym_ready, sample_stb, underrun;
  logic signed [15:0] i_out, q_out;

  logic reset4 = 1'b1;
  logic valid4 = 1'b1;
  logic [1:0] data4 = 2'b00;
  logic prbs_sel4 = 1'b0;
  logic ready4, stb4, under4;
  logic signed [15:0] i4, q4;

  always #5 clk = ~clk;

  qpsk_symbol_tx #(.SPS(SPS), .CLKS_PER_SAMPLE(CLKS), .AMP_I(AI), .AMP_Q(AQ)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .sym_valid  (sym_valid),
    .sym_data   (sym_data),
`ifdef QPSK_TX_PRBS_EN
    .prbs_sel   (prbs_sel),
`endif
    .sym_ready  (sym_ready),
    .I_out      (i_out),
    .Q_out      (q_out),
    .sample_stb (sample_stb),
    .underrun   (underrun)
  );

  qpsk_symbol_tx #(.SPS(4), .CLKS_PER_SAMPLE(CLKS), .AMP_I(AI), .AMP_Q(AQ)) u_dut4 (
    .clk        (clk),
    .reset      (reset4),
    .sym_valid  (valid4),
    .sym_data   (data4),
`ifdef QPSK_TX_PRBS_EN
    .prbs_sel   (prbs_sel4),
`endif
    .sym_ready  (ready4),
    .I_out      (i4),
    .Q_out      (q4),
    .sample_stb (stb4),
    .underrun   (under4)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  typedef struct {
    int i;
    int q;
    bit u;
  } exp_t;

  exp_t sb[$];
  logic [1:0] syms[$];
  int cap_i[$];
  int cap_q[$];

  int m_cnt = 0;
  int m_phase = SPS - 1;
  int m_prev_i = 0, m_curr_i = 0, m_prev_q = 0, m_curr_q = 0;
  bit m_under = 0;
  bit exp_stb = 0;
  bit exp_rst = 0;
  logic [8:0] m_lfsr = 9'h1FF;

  function automatic int interp(input int p, input int c, input int j);
    int num, qq;
    num = p * (SPS - 1 - j) + c * (j + 1);
    qq  = num / SPS;
    if ((num % SPS) != 0 && num < 0) qq--;
    return qq;
  endfunction

  function automatic logic prbs_bit();
    logic b;
    b      = m_lfsr[8] ^ m_lfsr[4];
    m_lfsr = {m_lfsr[7:0], b};
    return b;
  endfunction

  // One clock of stimulus + model; entered and left at a falling edge
  task automatic cycle();
    exp_t e;
    bit tick, slot, valid;
    logic [1:0] d;
    sym_valid = (syms.size() != 0);
    sym_data  = sym_valid ? syms[0] : 2'b00;
    #1;
    check("sample_stb", sample_stb, exp_stb);
    if (exp_rst) begin
      check("rst_i_out", i_out, 0);
      check("rst_q_out", q_out, 0);
      check("rst_underrun", underrun, 0);
    end
    if (sample_stb) begin
      cap_i.push_back(i_out);
      cap_q.push_back(q_out);
      if (sb.size() == 0) check("sb_nonempty", 0, 1);
      else begin
        e = sb.pop_front();
        check("i_out", i_out, e.i);
        check("q_out", q_out, e.q);
        check("underrun", underrun, e.u);
      end
    end
    tick = (m_cnt == CLKS - 1);
    slot = tick && (m_phase == SPS - 1);
    check("sym_ready", sym_ready, slot && !reset && !prbs_sel);
    if (reset) begin
      m_cnt = 0; m_phase = SPS - 1; m_under = 0; exp_stb = 0; exp_rst = 1;
      m_prev_i = 0; m_curr_i = 0; m_prev_q = 0; m_curr_q = 0;
      m_lfsr = 9'h1FF;
      sb.delete();
    end else begin
      exp_rst = 0;
      exp_stb = tick;
      if (tick) begin
        m_phase = (m_phase + 1) % SPS;
        if (slot) begin
          m_prev_i = m_curr_i;
          m_prev_q = m_curr_q;
          d = 2'b00;
          if (prbs_sel) begin
            d[1] = prbs_bit();
            d[0] = prbs_bit();
            valid = 1;
          end else begin
            valid = (syms.size() != 0);
            if (valid) d = syms.pop_front();
          end
          if (valid) begin
            m_curr_i = d[1] ? -AI : AI;
            m_curr_q = d[0] ? -AQ : AQ;
          end else begin
            m_curr_i = 0; m_curr_q = 0; m_under = 1;
          end
        end
        e.i = interp(m_prev_i, m_curr_i, m_phase);
        e.q = interp(m_prev_q, m_curr_q, m_phase);
        e.u = m_under;
        sb.push_back(e);
      end
      m_cnt = tick ? 0 : m_cnt + 1;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && syms.size() != 0; k++) cycle();
    check("drain_empty", syms.size(), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int exp_a_i[6] = '{11500, 23000, 0, -23000, 0, 23000};
  int exp_a_q[4] = '{12500, 25000, 0, -25000};
  int exp_b_i[4] = '{11500, 23000, 23000, 23000};
  int exp_c_i[5] = '{11500, 23000, 11500, 0, 0};

  // SPS=4 instance: symbol 00 then 11 forever; samples of both symbols are fixed values
  int q4_exp[$] = '{5750, 11500, 17250, 23000, 11500, 0, -11500, -23000};
  int acc4 = 0;

  always @(posedge clk) if (!reset4 && ready4 && valid4) acc4 <= acc4 + 1;

  always @(negedge clk) begin
    data4 = (acc4 == 0) ? 2'b00 : 2'b11;
    if (stb4 && q4_exp.size() != 0) check("sps4_i_out", i4, q4_exp.pop_front());
  end

  initial begin
    repeat (2) @(negedge clk);
    reset4 = 1'b0;
  end

  initial begin
    @(negedge clk);
    repeat (3) cycle();
    reset = 1'b0;

    // Alternating symbols, reset 5 clocks after the last acceptance
    syms = '{2'b00, 2'b11, 2'b00, 2'b11, 2'b00, 2'b11};
    cap_i.delete(); cap_q.delete();
    drain();
    repeat (5) cycle();
    check("alt_count", cap_i.size() >= 6, 1);
    for (int k = 0; k < 6 && k < cap_i.size(); k++) check("alt_i", cap_i[k], exp_a_i[k]);
    for (int k = 0; k < 4 && k < cap_q.size(); k++) check("alt_q", cap_q[k], exp_a_q[k]);
    pulse_reset();

    // Repeated symbol
    syms = '{2'b00, 2'b00, 2'b00};
    cap_i.delete(); cap_q.delete();
    drain();
    repeat (15) cycle();
    check("rep_count", cap_i.size() >= 4, 1);
    for (int k = 0; k < 4 && k < cap_i.size(); k++) check("rep_i", cap_i[k], exp_b_i[k]);
    pulse_reset();

    // One symbol then starvation
    syms = '{2'b00};
    cap_i.delete(); cap_q.delete();
    drain();
    repeat (100) cycle();
    check("starve_count", cap_i.size() >= 5, 1);
    for (int k = 0; k < 5 && k < cap_i.size(); k++) check("starve_i", cap_i[k], exp_c_i[k]);
    check("underrun_sticky", underrun, 1);
    pulse_reset();
    repeat (3) cycle();

`ifdef QPSK_TX_PRBS_EN
    // PRBS source with a pending external symbol that must be ignored
    prbs_sel = 1'b1;
    syms = '{2'b11};
    repeat (100 * SPS * CLKS + 5) cycle();
    prbs_sel = 1'b0;
    syms.delete();
    pulse_reset();
    repeat (3) cycle();
`endif

    check("sps4_remaining", q4_exp.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
